// File: rtl/comp_debounce.sv
// -----------------------------------------------------------------------------
// comp_debounce
//   Debounces the raw output of an analog comparator. The asynchronous input
//   is first passed through a two-flop synchronizer. A four-state FSM then
//   commits a new level only after the synchronized input has stayed at that
//   level for debounce_len extra cycles.
//
//   The block emits one-cycle rise and fall strobes and keeps sticky event
//   flags. It can optionally keep a saturating count of rising edges.
//
// Optional feature macro: COMP_EDGE_COUNT_EN (adds edge_count port + counter)
//
// Ports
//   wb_clk_i      in   clock, rising edge
//   wb_rst_i      in   synchronous active-high reset
//   comp_in       in   raw comparator level (asynchronous)
//   enable        in   1 = qualify, 0 = hold FSM in LOW
//   debounce_len  in   extra stable cycles required before commit (live)
//   clr_i         in   strobe: clears sticky flags (and edge_count)
//   comp_out      out  debounced level
//   rise_pulse    out  1-cycle strobe on committed rising edge
//   fall_pulse    out  1-cycle strobe on committed falling edge
//   sticky_rise   out  latched rise event
//   sticky_fall   out  latched fall event
//   edge_count    out  16-bit saturating rise count (macro only)
// -----------------------------------------------------------------------------
module comp_debounce #(
    parameter int CNT_W = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             comp_in,
    input  logic             enable,
    input  logic [CNT_W-1:0] debounce_len,
    input  logic             clr_i,
    output logic             comp_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             sticky_rise,
    output logic             sticky_fall
`ifdef COMP_EDGE_COUNT_EN
    ,
    output logic [15:0]      edge_count
`endif
);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_RISE_PEND = 2'd1,
        ST_HIGH      = 2'd2,
        ST_FALL_PEND = 2'd3
    } state_t;

    logic             r_sync1, r_sync2;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_commit;
    logic             w_rise_nxt, w_fall_nxt;
    logic             r_comp_out, r_rise, r_fall;
    logic             r_sticky_rise, r_sticky_fall;

    // The length is compared live. If it drops below the running count,
    // the FSM commits on the next edge. The count only advances while it is
    // below the length, so it can never wrap.
    assign w_commit = (r_cnt >= debounce_len);

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        if (!enable) begin
            // A forced drop to LOW is not a qualified edge, so no fall strobe.
            w_state_nxt = ST_LOW;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_LOW: begin
                    if (r_sync2) begin
                        w_state_nxt = ST_RISE_PEND;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_RISE_PEND: begin
                    if (!r_sync2) begin
                        w_state_nxt = ST_LOW;
                    end else if (w_commit) begin
                        w_state_nxt = ST_HIGH;
                        w_rise_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (!r_sync2) begin
                        w_state_nxt = ST_FALL_PEND;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_FALL_PEND: begin
                    if (r_sync2) begin
                        w_state_nxt = ST_HIGH;
                    end else if (w_commit) begin
                        w_state_nxt = ST_LOW;
                        w_fall_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Sequential logic. The outputs are registered from the next state, so
    // comp_out tracks the state register exactly.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_state       <= ST_LOW;
            r_cnt         <= '0;
            r_comp_out    <= 1'b0;
            r_rise        <= 1'b0;
            r_fall        <= 1'b0;
            r_sticky_rise <= 1'b0;
            r_sticky_fall <= 1'b0;
        end else begin
            r_sync1       <= comp_in;
            r_sync2       <= r_sync1;
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_comp_out    <= (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_FALL_PEND);
            r_rise        <= w_rise_nxt;
            r_fall        <= w_fall_nxt;
            // The flags are set from the visible strobe. A clear that lands
            // in the strobe cycle therefore loses to the set.
            r_sticky_rise <= r_rise | (r_sticky_rise & ~clr_i);
            r_sticky_fall <= r_fall | (r_sticky_fall & ~clr_i);
        end
    end

    assign comp_out    = r_comp_out;
    assign rise_pulse  = r_rise;
    assign fall_pulse  = r_fall;
    assign sticky_rise = r_sticky_rise;
    assign sticky_fall = r_sticky_fall;

`ifdef COMP_EDGE_COUNT_EN
    logic [15:0] r_edge_cnt;

    // Saturating count of rise strobes. An increment takes priority over a
    // clear; once saturated, the count holds at 0xFFFF.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_edge_cnt <= '0;
        end else if (r_rise) begin
            if (r_edge_cnt != 16'hFFFF) r_edge_cnt <= r_edge_cnt + 16'd1;
        end else if (clr_i) begin
            r_edge_cnt <= '0;
        end
    end

    assign edge_count = r_edge_cnt;
`endif

endmodule

// File: tb/tb_comp_debounce.sv
module tb_comp_debounce;

    logic       clk = 1'b0;
    logic       rst, ci, en, clr;
    logic [7:0] len;
    logic       out, rise, fall, srise, sfall;
`ifdef COMP_EDGE_COUNT_EN
    logic [15:0] ecnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    comp_debounce #(.CNT_W(8)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .comp_in     (ci),
        .enable      (en),
        .debounce_len(len),
        .clr_i       (clr),
        .comp_out    (out),
        .rise_pulse  (rise),
        .fall_pulse  (fall),
        .sticky_rise (srise),
        .sticky_fall (sfall)
`ifdef COMP_EDGE_COUNT_EN
        ,
        .edge_count  (ecnt)
`endif
    );

    // Behavioural reference model.
    //   - The synchronizer is a two-deep delay line.
    //   - m_run counts consecutive samples that differ from the committed level.
    //   - A commit needs the run to reach debounce_len + 2 samples: one sample
    //     to leave the stable state, debounce_len samples to count, and one
    //     sample to commit.
    bit m_s1, m_s2, m_lvl, m_rise, m_fall, m_srise, m_sfall;
    int m_run, m_ecnt;

    task automatic model_step();
        bit pr, pf;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_rise = 0; m_fall = 0;
            m_srise = 0; m_sfall = 0; m_run = 0; m_ecnt = 0;
        end else begin
            pr = m_rise; pf = m_fall;
            m_rise = 0; m_fall = 0;
            if (!en) begin
                m_lvl = 0; m_run = 0;
            end else if (m_s2 == m_lvl) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run >= int'(len) + 2) begin
                    m_lvl = !m_lvl;
                    m_run = 0;
                    if (m_lvl) m_rise = 1; else m_fall = 1;
                end
            end
            m_srise = pr || (m_srise && !clr);
            m_sfall = pf || (m_sfall && !clr);
            if (pr) begin
                if (m_ecnt < 65535) m_ecnt++;
            end else if (clr) m_ecnt = 0;
            m_s2 = m_s1;
            m_s1 = ci;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("model comp_out", 32'(out), 32'(m_lvl));
        chk("model rise_pulse", 32'(rise), 32'(m_rise));
        chk("model fall_pulse", 32'(fall), 32'(m_fall));
        chk("model sticky_rise", 32'(srise), 32'(m_srise));
        chk("model sticky_fall", 32'(sfall), 32'(m_sfall));
`ifdef COMP_EDGE_COUNT_EN
        chk("model edge_count", 32'(ecnt), 32'(m_ecnt));
`endif
    endtask

    // One clock edge. The model steps on the same inputs, then the outputs
    // are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cmp_model();
    endtask

    task automatic do_reset();
        rst = 1; clr = 0; en = 1; ci = 0;
        tick();
        rst = 0;
    endtask

    typedef struct {
        logic       ci, en, clr, rst;
        logic [7:0] len;
        logic       out, rise, fall, sr, sf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic c, logic cl, logic r,
                                logic o, logic ri, logic fa, logic s_r, logic s_f);
        vec_t v;
        v.ci = c; v.en = 1'b1; v.clr = cl; v.rst = r; v.len = 8'd3;
        v.out = o; v.rise = ri; v.fall = fa; v.sr = s_r; v.sf = s_f;
        return v;
    endfunction

    initial begin
        int n;
        bit seen;
        rst = 1; ci = 0; en = 1; clr = 0; len = 8'd3;

        // Table: debounce_len = 3, full rise then fall, then clear.
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));        // reset
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));    // qualifying high
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0));        // 6 edges after first sample
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0));
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0));    // qualifying low
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));        // clr drops both flags

        #1;
        foreach (tbl[i]) begin
            ci = tbl[i].ci; en = tbl[i].en; clr = tbl[i].clr;
            rst = tbl[i].rst; len = tbl[i].len;
            tick();
            chk($sformatf("tbl[%0d] comp_out", i), 32'(out), 32'(tbl[i].out));
            chk($sformatf("tbl[%0d] rise_pulse", i), 32'(rise), 32'(tbl[i].rise));
            chk($sformatf("tbl[%0d] fall_pulse", i), 32'(fall), 32'(tbl[i].fall));
            chk($sformatf("tbl[%0d] sticky_rise", i), 32'(srise), 32'(tbl[i].sr));
            chk($sformatf("tbl[%0d] sticky_fall", i), 32'(sfall), 32'(tbl[i].sf));
        end
        clr = 0;

        // Glitch of 3 cycles with debounce_len = 3 must be ignored.
        len = 8'd3; do_reset();
        ci = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("glitch quiet", {27'd0, out, rise, fall, srise, sfall}, 32'd0);
        end
        ci = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("glitch quiet", {27'd0, out, rise, fall, srise, sfall}, 32'd0);
        end

        // Dropping enable while HIGH: comp_out falls next edge, no fall strobe.
        do_reset();
        ci = 1;
        for (int i = 0; i < 8; i++) tick();
        chk("enable pre high", 32'(out), 32'd1);
        en = 0; ci = 0;
        tick();
        chk("enable drop comp_out", 32'(out), 32'd0);
        chk("enable drop fall_pulse", 32'(fall), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("enable idle fall_pulse", 32'(fall), 32'd0);
            chk("enable idle sticky_fall", 32'(sfall), 32'd0);
        end
        en = 1;

        // clr_i during the rise strobe: set wins, counter still increments.
        do_reset();
        ci = 1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = m_rise;
        end
        chk("clr/rise strobe reached", 32'(seen), 32'd1);
        clr = 1;
        tick();
        clr = 0;
        chk("clr/rise sticky_rise", 32'(srise), 32'd1);
`ifdef COMP_EDGE_COUNT_EN
        chk("clr/rise edge_count", 32'(ecnt), 32'd1);
`endif

        // Reset in RISE_PEND aborts with no strobe, then requalifies from LOW.
        do_reset();
        ci = 1;
        for (int i = 0; i < 4; i++) tick();
        rst = 1;
        tick();
        chk("rst pend outputs", {27'd0, out, rise, fall, srise, sfall}, 32'd0);
        rst = 0;
        n = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            n++;
            seen = rise;
        end
        chk("rst requalify seen", 32'(seen), 32'd1);
        chk("rst requalify edges", 32'(n), 32'd7);

        // Live length drop: len 10 -> 1 with the count already at 5.
        len = 8'd10; do_reset();
        ci = 1;
        for (int i = 0; i < 8; i++) tick();
        chk("live len pending", 32'(out), 32'd0);
        len = 8'd1;
        tick();
        chk("live len commit", 32'(rise), 32'd1);
        for (int i = 0; i < 3; i++) tick();

        // Randomized runs against the model.
        len = 8'd2; do_reset();
        for (int blk = 0; blk < 400; blk++) begin
            ci  = 1'($urandom_range(0, 1));
            en  = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 15) == 0) len = 8'($urandom_range(0, 5));
            n = $urandom_range(1, 9);
            for (int k = 0; k < n; k++) begin
                clr = ($urandom_range(0, 19) == 0);
                rst = ($urandom_range(0, 299) == 0);
                tick();
            end
        end
        rst = 0; clr = 0; en = 1;

`ifdef COMP_EDGE_COUNT_EN
        // Saturation: 65540 qualified rises with debounce_len = 0.
        len = 8'd0; do_reset();
        for (int i = 0; i < 65540 * 4 + 8; i++) begin
            ci = ((i % 4) < 2);
            tick();
        end
        chk("edge_count saturate", 32'(ecnt), 32'h0000FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/comp_debounce.md
COMP_DEBOUNCE -- requirements
Module: comp_debounce

Interface
REQ-001 The module SHALL have parameter CNT_W, default 8, giving the debounce length and counter width in bits (legal range 2..16).
REQ-002 The module SHALL have port wb_clk_i, input, 1 bit: the single clock; every flop is clocked on its rising edge.
REQ-003 The module SHALL have port wb_rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port comp_in, input, 1 bit: raw comparator output from the analog macro, asynchronous to wb_clk_i.
REQ-005 The module SHALL have port enable, input, 1 bit: 1 enables qualification, 0 holds the block idle.
REQ-006 The module SHALL have port debounce_len, input, CNT_W bits: the number of extra stable cycles required before committing a level.
REQ-007 The module SHALL have port clr_i, input, 1 bit: a one-cycle strobe that clears the sticky flags and the edge counter.
REQ-008 The module SHALL have port comp_out, output, 1 bit: the debounced comparator level.
REQ-009 The module SHALL have ports rise_pulse and fall_pulse, outputs, 1 bit each: one-cycle event strobes.
REQ-010 The module SHALL have ports sticky_rise and sticky_fall, outputs, 1 bit each: latched event flags.
REQ-011 The module SHALL have port edge_count, output, 16 bits, present only when COMP_EDGE_COUNT_EN is defined.

Function
REQ-012 comp_in SHALL pass through a 2-flop synchronizer (sync1, then sync2); only sync2 feeds the logic.
REQ-013 The FSM SHALL have states LOW, RISE_PEND, HIGH and FALL_PEND, plus a CNT_W-bit counter cnt.
REQ-014 LOW: if sync2=1, the FSM SHALL go to RISE_PEND with cnt<=0; otherwise it stays in LOW.
REQ-015 RISE_PEND: if sync2=0, the FSM SHALL return to LOW; else if cnt>=debounce_len, go to HIGH; else cnt<=cnt+1.
REQ-016 HIGH and FALL_PEND SHALL mirror REQ-014 and REQ-015 with the polarity inverted.
REQ-017 comp_out SHALL be registered and equal 1 exactly when the state is HIGH or FALL_PEND.
REQ-018 rise_pulse SHALL be 1 for exactly the first cycle of HIGH entered from RISE_PEND; fall_pulse SHALL behave likewise for LOW entered from FALL_PEND.
REQ-019 Latency: if edge k is the first edge to sample comp_in=1, comp_out and rise_pulse SHALL go to 1 after edge k+3+debounce_len.
REQ-020 A glitch shorter than debounce_len+1 cycles at sync2 SHALL produce no comp_out change and no pulse.
REQ-021 debounce_len SHALL be compared live; if it drops below cnt, the FSM commits on the next edge (>= compare) and cnt never wraps.
REQ-022 enable=0 SHALL force the state to LOW and comp_out to 0 on the next edge, with no fall_pulse, while the synchronizer keeps running.
REQ-023 sticky_rise SHALL set on rise_pulse and sticky_fall SHALL set on fall_pulse; clr_i clears both.
REQ-024 If clr_i and a pulse occur in the same cycle, the flag SHALL end up set (set wins).

Reset
REQ-025 When wb_rst_i=1 at a clock edge, the module SHALL set sync1, sync2, cnt and the sticky flags to 0, state to LOW, and comp_out, rise_pulse and fall_pulse to 0.
REQ-026 Reset SHALL override enable and clr_i, and SHALL abort any pending state with no pulse.

Configuration
REQ-027 With COMP_EDGE_COUNT_EN defined, edge_count SHALL increment on each rise_pulse, saturate at 0xFFFF, clear on clr_i (increment wins on a tie) and reset to 0.
REQ-028 Without COMP_EDGE_COUNT_EN, the edge_count port and its counter SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-029 Test: debounce_len=3, comp_in 0->1 held -> comp_out=1 and a single rise_pulse 6 cycles after the first sampling edge; sticky_rise=1.
REQ-030 Test: debounce_len=3, a 3-cycle high glitch -> comp_out stays 0, no pulses, sticky flags stay 0.
REQ-031 Test: comp_out=1, then enable=0 -> comp_out=0 next cycle and fall_pulse never asserts.
REQ-032 Test: clr_i in the same cycle as rise_pulse -> sticky_rise=1 and edge_count increments (macro defined).
REQ-033 Test: wb_rst_i asserted during RISE_PEND -> all outputs 0 next cycle; after release, the FSM requalifies from LOW.
REQ-034 Test: 65540 debounced rising edges with COMP_EDGE_COUNT_EN defined -> edge_count=0xFFFF.
